// File: rtl/line_window_buffer.sv
// line_window_buffer: keeps the last two active lines in three rotating line
// RAMs and emits a 3-tall vertical column {y-2, y-1, y} for every accepted
// pixel, with hcount/vcount/valid delay-matched to the 2-cycle data path.

// One line of pixel storage with a registered read port.
module lwb_line_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1280,
    parameter int AW    = 11
) (
    input  logic             clk_in,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Plain synchronous RAM, no reset so it maps onto block memory.
    always_ff @(posedge clk_in) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

module line_window_buffer #(
    parameter int PIXEL_WIDTH = 16,
    parameter int H_ACTIVE    = 1280,
    parameter int HC_WIDTH    = 11,
    parameter int VC_WIDTH    = 10
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     valid_in,
    input  logic [PIXEL_WIDTH-1:0]   pixel_in,
    input  logic [HC_WIDTH-1:0]      hcount_in,
    input  logic [VC_WIDTH-1:0]      vcount_in,
    output logic [3*PIXEL_WIDTH-1:0] column_out,
    output logic [HC_WIDTH-1:0]      hcount_out,
    output logic [VC_WIDTH-1:0]      vcount_out,
    output logic                     valid_out
);
    localparam int NUM_LINES = 3;
    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [HC_WIDTH-1:0] H_LAST = HC_WIDTH'(H_ACTIVE - 1);

    // Rotate a line index forward / backward modulo 3.
    function automatic logic [1:0] line_inc(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    function automatic logic [1:0] line_dec(input logic [1:0] l);
        return (l == 2'd0) ? 2'd2 : l - 2'd1;
    endfunction

    // Select one RAM's read data; index 3 never occurs.
    function automatic logic [PIXEL_WIDTH-1:0] pick(
        input logic [NUM_LINES-1:0][PIXEL_WIDTH-1:0] d,
        input logic [1:0]                            s
    );
        case (s)
            2'd0:    return d[0];
            2'd1:    return d[1];
            default: return d[2];
        endcase
    endfunction

    // ---------------- beat qualification and line bookkeeping ----------------
    logic          accept, frame_start, line_end;
    logic [1:0]    wr_line_q, wr_line_d, wr_eff;
    logic [1:0]    filled_q, filled_d, filled_eff;
    logic [AW-1:0] addr;

    assign accept      = valid_in && (hcount_in <= H_LAST);
    assign frame_start = accept && (hcount_in == '0) && (vcount_in == '0);
    assign line_end    = accept && (hcount_in == H_LAST);
    assign addr        = hcount_in[AW-1:0];

    // A frame-start beat already uses line 0 and an empty history.
    assign wr_eff     = frame_start ? 2'd0 : wr_line_q;
    assign filled_eff = frame_start ? 2'd0 : filled_q;

    // Rotation and fill count move only on accepted beats; ignored beats hold.
    always_comb begin
        wr_line_d = wr_line_q;
        filled_d  = filled_q;
        if (accept) begin
            wr_line_d = line_end ? line_inc(wr_eff) : wr_eff;
            filled_d  = (line_end && filled_eff != 2'd2) ? filled_eff + 2'd1 : filled_eff;
        end
    end

    // Write pointer and fill level.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_line_q <= 2'd0;
            filled_q  <= 2'd0;
        end else begin
            wr_line_q <= wr_line_d;
            filled_q  <= filled_d;
        end
    end

    // ---------------- line RAMs ----------------
    logic [NUM_LINES-1:0][PIXEL_WIDTH-1:0] rd_data;

    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        lwb_line_ram #(
            .WIDTH (PIXEL_WIDTH),
            .DEPTH (H_ACTIVE),
            .AW    (AW)
        ) u_ram (
            .clk_in  (clk_in),
            .we_i    (accept && (wr_eff == 2'(k))),
            .re_i    (accept),
            .addr_i  (addr),
            .wdata_i (pixel_in),
            .rdata_o (rd_data[k])
        );
    end

    // ---------------- stage 1: travels alongside the RAM read ----------------
    logic [1:0]             y1_sel_q, y2_sel_q;
    logic                   mask_y1_q, mask_y2_q;
    logic [PIXEL_WIDTH-1:0] pix_q;
    logic [HC_WIDTH-1:0]    hc_q;
    logic [VC_WIDTH-1:0]    vc_q;
    logic [1:0]             vld_pipe_q;

    // Line roles and fill mask are captured at sample time so they stay
    // aligned with the data they describe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            y1_sel_q  <= 2'd0;
            y2_sel_q  <= 2'd0;
            mask_y1_q <= 1'b1;
            mask_y2_q <= 1'b1;
            pix_q     <= '0;
            hc_q      <= '0;
            vc_q      <= '0;
        end else begin
            y1_sel_q  <= line_dec(wr_eff);
            y2_sel_q  <= line_inc(wr_eff);
            mask_y1_q <= (filled_eff == 2'd0);
            mask_y2_q <= (filled_eff != 2'd2);
            pix_q     <= pixel_in;
            hc_q      <= hcount_in;
            vc_q      <= vcount_in;
        end
    end

    // ---------------- stage 2: output registers ----------------
    logic [PIXEL_WIDTH-1:0]   y1_pix, y2_pix;
    logic [3*PIXEL_WIDTH-1:0] column_d;
    logic [3*PIXEL_WIDTH-1:0] column_q;
    logic [HC_WIDTH-1:0]      hcount_q;
    logic [VC_WIDTH-1:0]      vcount_q;

    // Assemble the column, oldest row in the top slice.
    always_comb begin
        y1_pix   = mask_y1_q ? '0 : pick(rd_data, y1_sel_q);
        y2_pix   = mask_y2_q ? '0 : pick(rd_data, y2_sel_q);
        column_d = {y2_pix, y1_pix, pix_q};
    end

    // Output registers and valid shift; valid only follows accepted beats.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            column_q   <= '0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            vld_pipe_q <= 2'b00;
        end else begin
            column_q   <= column_d;
            hcount_q   <= hc_q;
            vcount_q   <= vc_q;
            vld_pipe_q <= {vld_pipe_q[0], accept};
        end
    end

    assign column_out = column_q;
    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign valid_out  = vld_pipe_q[1];
endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: random line streams with gaps and out-of-range beats;
// expected columns come from a row-history model and are checked by a monitor.
module tb_line_window_buffer;
    localparam int PW  = 16;
    localparam int H   = 8;
    localparam int HCW = 11;
    localparam int VCW = 10;

    logic            clk = 1'b0;
    logic            rst_in = 1'b1;
    logic            valid_in = 1'b0;
    logic [PW-1:0]   pixel_in = '0;
    logic [HCW-1:0]  hcount_in = '0;
    logic [VCW-1:0]  vcount_in = '0;
    logic [3*PW-1:0] column_out;
    logic [HCW-1:0]  hcount_out;
    logic [VCW-1:0]  vcount_out;
    logic            valid_out;

    line_window_buffer #(
        .PIXEL_WIDTH (PW),
        .H_ACTIVE    (H),
        .HC_WIDTH    (HCW),
        .VC_WIDTH    (VCW)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .valid_in   (valid_in),
        .pixel_in   (pixel_in),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .column_out (column_out),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3*PW-1:0] col;
        logic [HCW-1:0]  hc;
        logic [VCW-1:0]  vc;
        int              due;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Reference: the last two completed rows of the current frame.
    logic [PW-1:0] prev1[H];
    logic [PW-1:0] prev2[H];
    logic [PW-1:0] cur[H];
    int filled = 0;

    // Monitor: valid_out must appear exactly when an expectation falls due.
    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        if (!rst_in) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                errors++;
                checks++;
                $display("FAIL missed_beat hc=%0d vc=%0d due=%0d now=%0d", e.hc, e.vc, e.due, cyc);
            end
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            checks++;
            if (valid_out !== exp_v) begin
                errors++;
                $display("FAIL valid_out cyc=%0d got=%b exp=%b", cyc, valid_out, exp_v);
            end
            if (exp_v) begin
                e = q.pop_front();
                checks++;
                if (column_out !== e.col || hcount_out !== e.hc || vcount_out !== e.vc) begin
                    errors++;
                    $display("FAIL column cyc=%0d got col=%h hc=%0d vc=%0d exp col=%h hc=%0d vc=%0d",
                             cyc, column_out, hcount_out, vcount_out, e.col, e.hc, e.vc);
                end
            end
        end
    end

    // Drive one cycle of input; accepted beats update the model and queue.
    task automatic beat(input bit v, input logic [PW-1:0] p,
                        input logic [HCW-1:0] h, input logic [VCW-1:0] vv);
        exp_t e;
        logic [PW-1:0] y1, y2;
        valid_in  = v;
        pixel_in  = p;
        hcount_in = h;
        vcount_in = vv;
        if (v && h < H) begin
            if (h == 0 && vv == 0) filled = 0;
            y1 = (filled >= 1) ? prev1[h] : '0;
            y2 = (filled >= 2) ? prev2[h] : '0;
            e.col = {y2, y1, p};
            e.hc  = h;
            e.vc  = vv;
            e.due = cyc + 2;
            q.push_back(e);
            cur[h] = p;
            if (h == H - 1) begin
                prev2 = prev1;
                prev1 = cur;
                if (filled < 2) filled++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Beats the DUT must ignore: idle cycles (sometimes at 0,0) or
    // out-of-range hcount with valid high.
    task automatic noise();
        case ($urandom_range(0, 3))
            0: beat(1'b0, PW'($urandom), '0, '0);
            1: beat(1'b0, PW'($urandom), HCW'($urandom_range(0, H - 1)), VCW'($urandom));
            2: beat(1'b1, PW'($urandom), HCW'(H + 3), VCW'($urandom));
            default: beat(1'b1, PW'($urandom), HCW'($urandom_range(H, 2047)), '0);
        endcase
    endtask

    // Send ncols columns of one row; pattern mode uses {row,col}.
    task automatic send_line(input int row, input int ncols, input bit pattern,
                             input bit gaps, input logic [PW-1:0] first_pix,
                             input bit use_first);
        logic [PW-1:0] p;
        for (int c = 0; c < ncols; c++) begin
            if (gaps) repeat ($urandom_range(0, 2)) noise();
            p = pattern ? {8'(row), 8'(c)} : PW'($urandom);
            if (use_first && c == 0) p = first_pix;
            beat(1'b1, p, HCW'(c), VCW'(row));
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (valid_out !== 1'b0 || column_out !== '0 || hcount_out !== '0 || vcount_out !== '0) begin
            errors++;
            $display("FAIL %s got valid=%b col=%h hc=%0d vc=%0d exp all zero",
                     name, valid_out, column_out, hcount_out, vcount_out);
        end
    endtask

    // Assert reset between clock edges; outputs must clear without an edge.
    task automatic async_reset();
        #2 rst_in = 1'b1;
        #1 check_zero("reset_async");
        q.delete();
        filled   = 0;
        valid_in = 1'b0;
        @(posedge clk);
        #1 rst_in = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < H; i++) begin
            prev1[i] = '0;
            prev2[i] = '0;
            cur[i]   = '0;
        end
        repeat (2) @(posedge clk);
        #1 check_zero("reset_init");
        rst_in = 1'b0;

        // Patterned fill and rotation wrap: rows 0..4, 0x1234 at (0,0).
        for (int r = 0; r < 5; r++) send_line(r, H, 1'b1, 1'b0, 16'h1234, r == 0);
        // Gaps and out-of-range beats interleaved.
        for (int r = 5; r < 8; r++) send_line(r, H, 1'b0, 1'b1, '0, 1'b0);
        // New frame with two lines already buffered.
        for (int r = 0; r < 3; r++) send_line(r, H, 1'b0, 1'b1, '0, 1'b0);
        // Reset mid-line, then resume without a frame start.
        send_line(3, 4, 1'b0, 1'b0, '0, 1'b0);
        async_reset();
        for (int r = 5; r < 7; r++) send_line(r, H, 1'b0, 1'b1, '0, 1'b0);
        // Lost line mid-frame, recovered by the next frame start.
        send_line(7, 3, 1'b0, 1'b0, '0, 1'b0);
        for (int r = 0; r < 4; r++) send_line(r, H, 1'b0, 1'b0, '0, 1'b0);
        // Random frames of varying height.
        for (int f = 0; f < 4; f++) begin
            int nrows;
            nrows = $urandom_range(1, 5);
            for (int r = 0; r < nrows; r++) send_line(r, H, 1'b0, f[0], '0, 1'b0);
        end

        repeat (4) beat(1'b0, '0, '0, '0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d exp 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
